mips_fetch_stage: RTL and testbench
===================================

// Module: mips_fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS32 pipeline. Owns the PC register and the IF/ID pipeline register.
//   Fetches from a handshaked instruction memory with at most one outstanding request.
//   Honours the hazard-unit stall and the branch/flush redirect from downstream.
//   Feeds IFID_pc4 / IFID_inst / IFID_valid to the ID stage (decode, register read, branch compare).
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   NOP_INST  32'h0000_0000  instruction word driven into IF/ID on bubble or flush (sll $0,$0,0)
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-low reset
//   stall          in   1   hazard unit: hold PC and IF/ID
//   flush          in   1   branch taken / redirect: squash the fetched instruction
//   branch_target  in   32  PC to fetch from when flush=1
//   imem_req       out  1   request valid to instruction memory
//   imem_addr      out  32  word address, always equal to pc_current
//   imem_gnt       in   1   memory accepts the request this cycle (imem_req && imem_gnt)
//   imem_rvalid    in   1   read data valid; earliest one cycle after the grant
//   imem_rdata     in   32  instruction word
//   pc_current     out  32  PC register
//   IFID_pc4       out  32  PC+4 of the instruction held in IF/ID
//   IFID_inst      out  32  instruction held in IF/ID
//   IFID_valid     out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//   Reset (async, reset=0):
//     pc_current=RESET_PC, state=FETCH, IFID_pc4=0, IFID_inst=NOP_INST, IFID_valid=0, buffer empty.
//     imem_req=1 from the first cycle after reset is released.
//   Combinational outputs:
//     imem_req = (state==FETCH) && !flush.
//     imem_addr = pc_current.
//   FSM (one outstanding request):
//     FETCH
//       flush -> pc<=branch_target, stay FETCH.
//       gnt   -> WAIT.
//       else  -> stay FETCH.
//     WAIT
//       rvalid && flush   -> pc<=branch_target, drop rdata, FETCH.
//       rvalid && stall   -> buf<=rdata, HOLD.
//       rvalid            -> IF/ID<={pc+4, rdata, 1}, pc<=pc+4, FETCH.
//       !rvalid && flush  -> pc<=branch_target, DROP.
//     HOLD
//       flush   -> pc<=branch_target, discard buf, FETCH.
//       !stall  -> IF/ID<={pc+4, buf, 1}, pc<=pc+4, FETCH.
//     DROP
//       (the in-flight response belongs to the old path)
//       rvalid -> discard, FETCH.
//       flush  -> pc<=branch_target, stay DROP; the later target wins.
//   IF/ID register, same edge, priority order:
//     1. flush        -> {0, NOP_INST, 0}.
//     2. stall        -> hold.
//     3. new instruction (WAIT+rvalid, or HOLD release) -> load.
//     4. otherwise    -> bubble {0, NOP_INST, 0}.
//   flush overrides stall everywhere, including in HOLD.
//   Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0). Bits [1:0] are passed through unchecked.
//   Latency: gnt in cycle N, rvalid in N+1 -> IF/ID valid after edge N+1.
//     Zero-wait memory throughput: 1 instruction per 2 cycles.
//   imem_rvalid outside WAIT/DROP is ignored.
//   imem_gnt is only sampled while imem_req=1.
//   Reset mid-request: the FSM returns to FETCH. A stale rvalid arriving afterwards is ignored (state is FETCH).
// TESTING
//   1. Reset release, gnt=1 always, rvalid one cycle later, rdata=0x2002_0005 at PC 0
//      -> IFID_inst=0x2002_0005, IFID_pc4=4, IFID_valid=1, pc_current=4.
//   2. stall=1 for 3 cycles while in WAIT with rvalid
//      -> HOLD; IF/ID and PC frozen; on release IF/ID loads the buffered word once, with no duplicate.
//   3. flush=1 with branch_target=0x40 while in WAIT without rvalid
//      -> DROP; the next rvalid is discarded; the next imem_addr is 0x40; IFID_valid=0 throughout.
//   4. stall=1 and flush=1 in the same cycle in HOLD
//      -> IF/ID becomes NOP/valid=0; pc=target; buffer discarded.
//   5. PC=0xFFFF_FFFC fetch completes -> IFID_pc4=0, pc_current=0.
//   6. reset asserted while in WAIT, rvalid pulsed after release
//      -> pc=RESET_PC; the stale rvalid does not load IF/ID; normal fetch resumes.

Source files
------------

// File: rtl/mips_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// mips_fetch_stage_if : instruction-memory request/response bus, one outstanding
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface mips_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

`default_nettype wire

// File: rtl/mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// mips_fetch_stage : MIPS32 IF stage - PC register, imem fetch FSM, IF/ID register
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        stall,
  input  wire logic        flush,
  input  wire logic [31:0] branch_target,
  mips_fetch_stage_if.master imem,
  output logic [31:0]      pc_current,
  output logic [31:0]      IFID_pc4,
  output logic [31:0]      IFID_inst,
  output logic             IFID_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] w_pc_plus4;
  logic        w_load_new;
  logic [31:0] w_new_inst;

  assign w_pc_plus4 = pc_q + 32'd4;

  assign imem.req   = (state_q == S_FETCH) && !flush;
  assign imem.addr  = pc_q;
  assign pc_current = pc_q;
  assign IFID_pc4   = ifid_pc4_q;
  assign IFID_inst  = ifid_inst_q;
  assign IFID_valid = ifid_valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    w_load_new = 1'b0;
    w_new_inst = buf_q;

    case (state_q)
      S_FETCH: begin
        if (flush) begin
          pc_d = branch_target;
        end else if (imem.gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          if (flush) begin
            pc_d    = branch_target;
            state_d = S_FETCH;
          end else if (stall) begin
            buf_d   = imem.rdata;
            state_d = S_HOLD;
          end else begin
            w_load_new = 1'b1;
            w_new_inst = imem.rdata;
            pc_d       = w_pc_plus4;
            state_d    = S_FETCH;
          end
        end else if (flush) begin
          pc_d    = branch_target;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_d    = branch_target;
          buf_d   = NOP_INST;
          state_d = S_FETCH;
        end else if (!stall) begin
          w_load_new = 1'b1;
          w_new_inst = buf_q;
          pc_d       = w_pc_plus4;
          state_d    = S_FETCH;
        end
      end
      S_DROP: begin
        // The response in flight belongs to the abandoned path; only the PC moves.
        if (flush) begin
          pc_d = branch_target;
        end
        if (imem.rvalid) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ifid_pc4_d   = 32'd0;
    ifid_inst_d  = NOP_INST;
    ifid_valid_d = 1'b0;
    if (flush) begin
      ifid_pc4_d   = 32'd0;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      ifid_pc4_d   = ifid_pc4_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_valid_d = ifid_valid_q;
    end else if (w_load_new) begin
      ifid_pc4_d   = w_pc_plus4;
      ifid_inst_d  = w_new_inst;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      buf_q        <= NOP_INST;
      ifid_pc4_q   <= 32'd0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_stage : cycle-vector bench for the MIPS32 IF stage
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_fetch_stage;

  typedef struct packed {
    logic        st;
    logic        fl;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        req_e;
    logic [31:0] pc_e;
    logic [31:0] pc4_e;
    logic [31:0] inst_e;
    logic        valid_e;
  } vec_t;

  localparam int c_NVEC = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] pc_current;
  logic [31:0] IFID_pc4;
  logic [31:0] IFID_inst;
  logic        IFID_valid;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc = 32'h0;
  vec_t        sb[$];
  vec_t        tbl[c_NVEC];

  mips_fetch_stage_if imem ();

  mips_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem          (imem.master),
    .pc_current    (pc_current),
    .IFID_pc4      (IFID_pc4),
    .IFID_inst     (IFID_inst),
    .IFID_valid    (IFID_valid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic fl, input logic [31:0] tgt,
                              input logic gnt, input logic rv, input logic [31:0] rd,
                              input logic req, input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [31:0] inst, input logic vld);
    vec_t v;
    v.st = st; v.fl = fl; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rdata = rd;
    v.req_e = req; v.pc_e = pc; v.pc4_e = pc4; v.inst_e = inst; v.valid_e = vld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational request, check registers after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    stall         = v.st;
    flush         = v.fl;
    branch_target = v.tgt;
    imem.gnt      = v.gnt;
    imem.rvalid   = v.rv;
    imem.rdata    = v.rdata;
    sb.push_back(v);
    #1;
    chk({tag, ".imem_req"}, {31'd0, imem.req}, {31'd0, v.req_e});
    chk({tag, ".imem_addr"}, imem.addr, exp_pc);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc_current"}, pc_current, e.pc_e);
    chk({tag, ".IFID_pc4"}, IFID_pc4, e.pc4_e);
    chk({tag, ".IFID_inst"}, IFID_inst, e.inst_e);
    chk({tag, ".IFID_valid"}, {31'd0, IFID_valid}, {31'd0, e.valid_e});
    exp_pc = e.pc_e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Flow: fetch, stall-in-WAIT/HOLD, flush-in-WAIT/DROP, flush+stall in HOLD, redirects.
    tbl[0]  = mk(0,0,32'h0,  1,0,32'h0,        1, 32'h0,   32'h0,   32'h0,         0);
    tbl[1]  = mk(0,0,32'h0,  1,1,32'h2002_0005,0, 32'h4,   32'h4,   32'h2002_0005, 1);
    tbl[2]  = mk(1,0,32'h0,  1,0,32'h0,        1, 32'h4,   32'h4,   32'h2002_0005, 1);
    tbl[3]  = mk(1,0,32'h0,  0,1,32'hAAAA_0001,0, 32'h4,   32'h4,   32'h2002_0005, 1);
    tbl[4]  = mk(1,0,32'h0,  0,1,32'hDEAD_0000,0, 32'h4,   32'h4,   32'h2002_0005, 1);
    tbl[5]  = mk(1,0,32'h0,  0,0,32'h0,        0, 32'h4,   32'h4,   32'h2002_0005, 1);
    tbl[6]  = mk(0,0,32'h0,  0,0,32'h0,        0, 32'h8,   32'h8,   32'hAAAA_0001, 1);
    tbl[7]  = mk(0,0,32'h0,  0,0,32'h0,        1, 32'h8,   32'h0,   32'h0,         0);
    tbl[8]  = mk(0,0,32'h0,  1,0,32'h0,        1, 32'h8,   32'h0,   32'h0,         0);
    tbl[9]  = mk(0,1,32'h40, 0,0,32'h0,        0, 32'h40,  32'h0,   32'h0,         0);
    tbl[10] = mk(0,0,32'h0,  0,0,32'h0,        0, 32'h40,  32'h0,   32'h0,         0);
    tbl[11] = mk(0,0,32'h0,  0,1,32'hBAD0_0000,0, 32'h40,  32'h0,   32'h0,         0);
    tbl[12] = mk(0,0,32'h0,  1,0,32'h0,        1, 32'h40,  32'h0,   32'h0,         0);
    tbl[13] = mk(0,0,32'h0,  0,1,32'h1111_2222,0, 32'h44,  32'h44,  32'h1111_2222, 1);
    tbl[14] = mk(1,0,32'h0,  1,0,32'h0,        1, 32'h44,  32'h44,  32'h1111_2222, 1);
    tbl[15] = mk(1,0,32'h0,  0,1,32'h3333_4444,0, 32'h44,  32'h44,  32'h1111_2222, 1);
    tbl[16] = mk(1,1,32'h100,0,0,32'h0,        0, 32'h100, 32'h0,   32'h0,         0);
    tbl[17] = mk(0,0,32'h0,  0,0,32'h0,        1, 32'h100, 32'h0,   32'h0,         0);
    tbl[18] = mk(0,0,32'h0,  1,0,32'h0,        1, 32'h100, 32'h0,   32'h0,         0);
    tbl[19] = mk(0,0,32'h0,  0,1,32'h5555_6666,0, 32'h104, 32'h104, 32'h5555_6666, 1);
    tbl[20] = mk(0,0,32'h0,  1,0,32'h0,        1, 32'h104, 32'h0,   32'h0,         0);
    tbl[21] = mk(0,1,32'h200,0,0,32'h0,        0, 32'h200, 32'h0,   32'h0,         0);
    tbl[22] = mk(0,1,32'h300,0,0,32'h0,        0, 32'h300, 32'h0,   32'h0,         0);
    tbl[23] = mk(0,0,32'h0,  0,1,32'hCAFE_0000,0, 32'h300, 32'h0,   32'h0,         0);
    tbl[24] = mk(0,1,32'h400,1,0,32'h0,        0, 32'h400, 32'h0,   32'h0,         0);
    tbl[25] = mk(0,0,32'h0,  1,0,32'h0,        1, 32'h400, 32'h0,   32'h0,         0);
    tbl[26] = mk(0,1,32'h500,0,1,32'h9999_0000,0, 32'h500, 32'h0,   32'h0,         0);
    tbl[27] = mk(0,0,32'h0,  1,0,32'h0,        1, 32'h500, 32'h0,   32'h0,         0);
    tbl[28] = mk(0,0,32'h0,  0,0,32'h0,        0, 32'h500, 32'h0,   32'h0,         0);
    tbl[29] = mk(0,0,32'h0,  0,1,32'h7777_8888,0, 32'h504, 32'h504, 32'h7777_8888, 1);

    reset = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = 32'h0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.pc_current", pc_current, 32'h0);
    chk("reset.IFID_pc4", IFID_pc4, 32'h0);
    chk("reset.IFID_inst", IFID_inst, 32'h0);
    chk("reset.IFID_valid", {31'd0, IFID_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < c_NVEC; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while waiting on a response; stale rvalid afterwards must be ignored.
    apply(mk(0,0,32'h0,1,0,32'h0, 1, 32'h504, 32'h0, 32'h0, 0), "rst_mid.grant");
    @(negedge clk);
    imem.gnt = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.pc_current", pc_current, 32'h0);
    chk("rst_mid.IFID_valid", {31'd0, IFID_valid}, 32'd0);
    chk("rst_mid.IFID_pc4", IFID_pc4, 32'h0);
    @(negedge clk);
    reset  = 1'b1;
    exp_pc = 32'h0;
    apply(mk(0,0,32'h0,0,1,32'hDEAD_BEEF, 1, 32'h0, 32'h0, 32'h0, 0), "rst_mid.stale");
    apply(mk(0,0,32'h0,1,0,32'h0,         1, 32'h0, 32'h0, 32'h0, 0), "rst_mid.regrant");
    apply(mk(0,0,32'h0,0,1,32'h2002_0005, 0, 32'h4, 32'h4, 32'h2002_0005, 1), "rst_mid.resume");

    // PC wrap at the top of the address space.
    apply(mk(0,1,32'hFFFF_FFFC,1,0,32'h0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0), "wrap.redirect");
    apply(mk(0,0,32'h0,1,0,32'h0,         1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0), "wrap.grant");
    apply(mk(0,0,32'h0,0,1,32'h0C00_0000, 0, 32'h0, 32'h0, 32'h0C00_0000, 1), "wrap.data");
    apply(mk(0,0,32'h0,0,0,32'h0,         1, 32'h0, 32'h0, 32'h0, 0), "wrap.next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
